// File: rtl/cfs_md_sink.sv
// MD transfer responder: programmable wait states, offset/size legality check,
// and unpacking of legal payload bytes into a byte FIFO drained by a valid/ready stream.
module cfs_md_sink #(
    parameter  int ALGN_DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH      = 16,
    localparam int NB = ALGN_DATA_WIDTH / 8,
    localparam int OW = (NB > 1) ? $clog2(NB) : 1,
    localparam int SW = $clog2(NB) + 1,
    localparam int FW = $clog2(FIFO_DEPTH + 1),
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_md_valid,
    input  logic [ALGN_DATA_WIDTH-1:0] i_md_data,
    input  logic [OW-1:0]              i_md_offset,
    input  logic [SW-1:0]              i_md_size,
    output logic                       o_md_ready,
    output logic                       o_md_err,
    input  logic [3:0]                 i_cfg_wait,
    output logic                       o_out_valid,
    output logic [7:0]                 o_out_data,
    input  logic                       i_out_ready,
    output logic [FW-1:0]              o_fill_level,
    output logic [15:0]                o_cnt_ok,
    output logic [15:0]                o_cnt_err,
    output logic                       o_proto_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [3:0]                 r_wcnt;
    logic                       r_legal;
    logic [ALGN_DATA_WIDTH-1:0] r_data;
    logic [OW-1:0]              r_offset;
    logic [SW-1:0]              r_size;
    logic                       r_md_ready;
    logic                       r_md_err;
    logic [15:0]                r_cnt_ok;
    logic [15:0]                r_cnt_err;
    logic                       r_proto_err;

    logic [7:0]                 r_mem [FIFO_DEPTH];
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [FW-1:0]              r_fill;

    logic                       w_legal;
    logic                       w_proto;
    logic [FW-1:0]              w_space;
    logic                       w_push;
    logic                       w_pop;
    logic [SW-1:0]              w_push_cnt;
    logic [ALGN_DATA_WIDTH-1:0] w_shift;
    logic [PW-1:0]              w_idx [NB];

    // Pointer advance with explicit wrap so FIFO_DEPTH need not be a power of two.
    function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] p, input logic [SW-1:0] k);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(k);
        if (s >= (PW+1)'(FIFO_DEPTH)) s = s - (PW+1)'(FIFO_DEPTH);
        return s[PW-1:0];
    endfunction

    assign w_legal    = (i_md_size != '0) &&
                        ((SW+1)'(i_md_offset) + (SW+1)'(i_md_size) <= (SW+1)'(NB));
    assign w_space    = FW'(FIFO_DEPTH) - r_fill;
    assign w_push     = (r_state == S_RESP) && r_legal;
    assign w_pop      = (r_fill != '0) && i_out_ready;
    assign w_push_cnt = w_push ? r_size : '0;
    assign w_shift    = r_data >> {r_offset, 3'b000};

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_proto     = 1'b0;
        case (r_state)
            S_IDLE: if (i_md_valid) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!i_md_valid) begin
                    w_proto     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wcnt == 4'd0 && (!r_legal || w_space >= FW'(r_size))) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NB; i++) w_idx[i] = f_wrap(r_wr_ptr, SW'(i));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_legal     <= 1'b0;
            r_data      <= '0;
            r_offset    <= '0;
            r_size      <= '0;
            r_md_ready  <= 1'b0;
            r_md_err    <= 1'b0;
            r_cnt_ok    <= '0;
            r_cnt_err   <= '0;
            r_proto_err <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_md_ready <= (w_state_nxt == S_RESP);
            r_md_err   <= (w_state_nxt == S_RESP) && !r_legal;
            if (r_state == S_IDLE && i_md_valid) begin
                r_wcnt   <= i_cfg_wait;
                r_legal  <= w_legal;
                r_data   <= i_md_data;
                r_offset <= i_md_offset;
                r_size   <= i_md_size;
            end
            if (r_state == S_WAIT && r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
            if (r_state == S_RESP) begin
                if (r_legal && r_cnt_ok != 16'hFFFF) r_cnt_ok <= r_cnt_ok + 16'd1;
                if (!r_legal && r_cnt_err != 16'hFFFF) r_cnt_err <= r_cnt_err + 16'd1;
            end
            if (w_proto) r_proto_err <= 1'b1;
            if (w_push) r_wr_ptr <= f_wrap(r_wr_ptr, r_size);
            if (w_pop) r_rd_ptr <= f_wrap(r_rd_ptr, SW'(1));
            r_fill <= r_fill + FW'(w_push_cnt) - FW'(w_pop);
        end
    end

    // NOTE: storage is not reset; out_data is masked while empty so stale contents never leak.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_push && SW'(i) < r_size) r_mem[w_idx[i]] <= w_shift[i*8 +: 8];
        end
    end

    assign o_md_ready   = r_md_ready;
    assign o_md_err     = r_md_err;
    assign o_out_valid  = (r_fill != '0);
    assign o_out_data   = (r_fill != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign o_fill_level = r_fill;
    assign o_cnt_ok     = r_cnt_ok;
    assign o_cnt_err    = r_cnt_err;
    assign o_proto_err  = r_proto_err;

endmodule

// File: doc/cfs_md_sink.md
# cfs_md_sink

Memory-data (MD) responder that terminates the aligner's MD_TX output. It accepts MD transfers with programmable wait states, checks offset/size legality, and answers each transfer with ready, plus err when the transfer is illegal. Legal payload bytes are unpacked into an internal byte FIFO and drained one byte per cycle through a valid/ready stream. It also serves as the reference sink model in aligner-level benches.

## Interface
- ALGN_DATA_WIDTH, 32: MD data width in bits; power of two, ≥ 8. Let NB = ALGN_DATA_WIDTH/8.
- FIFO_DEPTH, 16: byte FIFO capacity in bytes; must be ≥ NB.
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- md_valid  in  1  transfer request from the MD initiator.
- md_data  in  ALGN_DATA_WIDTH  transfer data.
- md_offset  in  clog2(NB)  first valid byte lane.
- md_size  in  clog2(NB)+1  number of valid bytes.
- md_ready  out  1  registered; one-cycle pulse that completes the transfer.
- md_err  out  1  registered; valid only while md_ready=1.
- cfg_wait  in  4  wait cycles inserted before md_ready; sampled when a transfer is first seen.
- out_valid  out  1  byte available (FIFO not empty).
- out_data  out  8  byte at the FIFO head.
- out_ready  in  1  consumer accepts the byte.
- fill_level  out  clog2(FIFO_DEPTH+1)  bytes currently stored.
- cnt_ok  out  16  count of legal completed transfers; saturates at 0xFFFF.
- cnt_err  out  16  count of illegal completed transfers; saturates.
- proto_err  out  1  sticky flag; set when md_valid drops before md_ready. Cleared only by reset.

## Operation
- Legality: a transfer is legal iff md_size != 0 and md_offset + md_size ≤ NB. The sum is computed one bit wider than md_size, so it cannot overflow.
- State machine with three states: IDLE, WAIT, RESP.
  - IDLE: when md_valid=1, load wcnt = cfg_wait, latch legality, and go to WAIT.
  - WAIT: while wcnt != 0, decrement wcnt. When wcnt = 0:
    - If illegal, go to RESP.
    - If legal and FIFO_DEPTH − fill_level ≥ md_size, go to RESP.
    - Otherwise stay in WAIT (backpressure stall) until space frees.
  - RESP: md_ready=1 for exactly this cycle, and md_err=1 if illegal.
    - If legal, push md_size bytes, lanes md_offset .. md_offset+md_size−1, in ascending lane order. The lowest lane enters the FIFO first.
    - Increment cnt_ok or cnt_err.
    - Return to IDLE. A back-to-back md_valid is first evaluated in the following IDLE cycle.
- md_valid=0 in WAIT: set proto_err, return to IDLE, push nothing, count nothing.
- FIFO: circular byte buffer with wrapping read/write pointers.
  - Multi-byte write (1..NB bytes) and single-byte read in the same cycle are both allowed.
  - fill_level_next = fill_level + pushed − popped.
  - The space check uses the current fill_level, so a simultaneous pop does not create headroom for the push.
- out_data and out_valid reflect the FIFO head. A pop happens when out_valid && out_ready. out_ready while empty has no effect.
- Reset, including mid-transfer: state returns to IDLE; FIFO pointers, fill_level, counters and proto_err clear. An in-flight transfer is dropped without md_ready.

## Timing
- Reset values: md_ready=0, md_err=0, out_valid=0, out_data=0, fill_level=0, cnt_ok=0, cnt_err=0, proto_err=0.
- Latency from md_valid seen in IDLE (cycle 0) to md_ready, with no stall: cycle cfg_wait + 2 (cfg_wait=0 gives md_ready in cycle 2).
- Stall cycles add 1:1 to that latency.
- Pushed bytes become visible at the next edge: out_valid=1 the cycle after RESP when the FIFO was empty.
- Maximum transfer rate: one transfer every 3 cycles at cfg_wait=0.
- Drain rate: one byte per cycle.

## Test plan
- Single legal transfer: cfg_wait=0, md_data=0xDDCCBBAA, offset=1, size=2 → md_ready in cycle 2 with md_err=0; out stream 0xBB then 0xCC; cnt_ok=1.
- Illegal transfers: offset=3, size=2, then offset=0, size=0 → two md_ready pulses with md_err=1; fill_level stays 0; cnt_err=2.
- Wait states: cfg_wait=5 → md_ready exactly in cycle 7; md_ready never asserted before that.
- Full backpressure: FIFO_DEPTH=16, out_ready=0, four size-4 transfers reach fill_level=16; a fifth transfer stalls with md_ready=0; raising out_ready completes it only once fill_level ≤ 12 is observed in WAIT; total bytes drained = 20, in order.
- Pointer wrap and concurrency: 40 random legal transfers with random out_ready → byte stream matches the reference byte queue exactly; fill_level never exceeds 16.
- Protocol and reset: drop md_valid during WAIT → proto_err=1, no md_ready. Assert reset_n=0 mid-WAIT → all outputs return to reset values the next edge, and proto_err clears.
